fb_port_a_scheduler: RTL and testbench
======================================

Name: fb_port_a_scheduler

Overview:
- Owns Port A of the 1-bit frame buffer and shares it between two requesters: the microprocessor (single-pixel read/write) and a built-in rectangle-fill engine (clear screen, draw/erase car and road blocks).
- Sits between the CPU bus glue and the frame buffer.
- The fill engine walks a clipped rectangle in raster order and issues one pixel write per granted cycle.
- CPU and fill engine are arbitrated round-robin.

Parameters:
- HorRes, 160, horizontal resolution in pixels; must be ≤ 256.
- VertRes, 120, vertical resolution in pixels; must be ≤ 128.

Ports:
- CLK  in  1  single system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CPU_REQ  in  1  CPU access request; held until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_ADDR  in  15  pixel address {Y[14:8], X[7:0]}.
- CPU_WDATA  in  1  pixel value to write.
- CPU_ACK  out  1  one-cycle pulse; the CPU access is on FB_* this cycle.
- CPU_RVALID  out  1  one-cycle pulse; CPU_RDATA is valid.
- CPU_RDATA  out  1  read pixel.
- FILL_START  in  1  one-cycle command strobe.
- FILL_X0  in  8  rectangle left edge.
- FILL_Y0  in  7  rectangle top edge.
- FILL_W  in  8  width in pixels.
- FILL_H  in  7  height in pixels.
- FILL_COLOUR  in  1  fill value.
- FILL_BUSY  out  1  fill in progress.
- FILL_DONE  out  1  one-cycle completion pulse.
- FB_ADDR  out  15  to frame buffer A_ADDR.
- FB_WE  out  1  to A_WE.
- FB_WDATA  out  1  to A_DATA_IN.
- FB_RDATA  in  1  from A_DATA_OUT; valid one cycle after the address is presented.

Behaviour:
- Reset (async, RESET_N = 0): FSM to IDLE. All outputs are 0: CPU_ACK, CPU_RVALID, CPU_RDATA, FILL_BUSY, FILL_DONE, FB_ADDR, FB_WE, FB_WDATA. Round-robin pointer set to "CPU last". A fill in progress is abandoned with no DONE pulse. A pending read returns no RVALID.
- FB_ADDR, FB_WE, FB_WDATA, CPU_ACK, FILL_BUSY and FILL_DONE are registered.
- CPU eligibility: CPU_REQ = 1 and CPU_ACK = 0 in that cycle. The CPU therefore gets at most one grant every 2 cycles, which prevents a double issue while the CPU drops REQ.
- Fill eligibility: FSM in FILL.
- Arbitration, evaluated each cycle:
  - Only one eligible requester: it is granted.
  - Both eligible: grant the one not granted last.
  - Pointer update: the pointer changes only on a grant.
- CPU grant:
  - Next cycle: FB_ADDR = CPU_ADDR, FB_WE = CPU_WE, FB_WDATA = CPU_WDATA, CPU_ACK = 1.
  - Read timing: ACK in cycle C → FB_RDATA valid in C+1 → CPU_RDATA registered with CPU_RVALID = 1 in C+2.
  - The 2-cycle read latency is independent of fill traffic.
- Fill grant: next cycle FB_ADDR = {cy, cx}, FB_WE = 1, FB_WDATA = latched colour.
- No grant: FB_WE = 0. FB_ADDR and FB_WDATA hold their last value.
- FSM states: IDLE, FILL, DONE.
  - IDLE + FILL_START:
    - Latch the command and compute x_end = min(X0 + W − 1, HorRes − 1) and y_end = min(Y0 + H − 1, VertRes − 1), using 9-/8-bit intermediates with no wrap.
    - Empty case: W = 0, H = 0, X0 ≥ HorRes or Y0 ≥ VertRes → go to DONE with no writes.
    - Otherwise set cx = X0, cy = Y0 and go to FILL.
  - FILL: on each fill grant, step the raster counters:
    - cx = x_end and cy = y_end: last pixel, go to DONE.
    - cx = x_end otherwise: cx = X0, cy++.
    - otherwise: cx++.
  - DONE: FILL_DONE = 1 for exactly one cycle, then return to IDLE.
- FILL_BUSY = 1 in FILL and DONE-entry transit, i.e. from the cycle after START until the cycle before DONE is visible. FILL_BUSY and FILL_DONE are never high together.
- FILL_START is ignored unless the FSM is in IDLE. START in the DONE cycle is ignored.
- Uncontended fill of N pixels: START sampled at edge 0 → writes in cycles 1..N → DONE in cycle N+1.
- CPU writes are not address-checked. The frame buffer tolerates out-of-range X or Y.

Decomposition:
- Package fb_pkg:
  - address field widths (X_W = 8, Y_W = 7, ADDR_W = 15);
  - FSM state encoding;
  - function pack_addr(y, x).
- One sub-module, fb_rect_walker: latched bounds, cx/cy counters, clip computation, and a "last" flag. Interface: start, step, empty, last, addr.
- Arbiter, registers and the CPU read pipeline stay in the top module.

Test Plan:
- Reset, then CPU write to {Y=5, X=7} with data 1 → ACK next cycle with FB_ADDR = 0x0507, FB_WE = 1, FB_WDATA = 1. Then CPU read of the same address with a frame-buffer model → RVALID 2 cycles after ACK with RDATA = 1.
- Fill X0=10, Y0=20, W=3, H=2, colour 1, no CPU traffic → six writes in consecutive cycles at 0x140A, 0x140B, 0x140C, 0x150A, 0x150B, 0x150C. DONE in cycle 7. BUSY high in cycles 1–6.
- Fill X0=158, Y0=119, W=5, H=4 → clipped to 2 writes, 0x779E and 0x779F, then DONE. Fill W=0 → DONE in cycle 1, zero writes.
- CPU_REQ held high continuously during a 10-pixel fill → grants alternate fill/CPU every cycle. CPU gets ACK every 2nd cycle. The fill completes after exactly 10 fill writes, and no CPU access is issued twice.
- RESET_N pulsed low in the middle of a fill → outputs go to 0 immediately (asynchronously). No DONE pulse. A following FILL_START is accepted normally.
- FILL_START while BUSY → ignored: no change to bounds, and the write count equals the first command only.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer address fields, scheduler states and address packing
package fb_pkg;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ADDR_W = X_W + Y_W;

    typedef logic [1:0] fb_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// rtl/fb_rect_walker.sv - clipped rectangle raster walker for the fill engine
module fb_rect_walker
    import fb_pkg::*;
#(
    parameter int HOR_RES  = 160,
    parameter int VERT_RES = 120
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    output logic              empty,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [X_W:0] X_LIM  = (X_W+1)'(HOR_RES);
    localparam logic [Y_W:0] Y_LIM  = (Y_W+1)'(VERT_RES);
    localparam logic [X_W:0] X_LAST = (X_W+1)'(HOR_RES - 1);
    localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(VERT_RES - 1);

    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic [X_W-1:0] x_end_d;
    logic [Y_W-1:0] y_end_d;
    logic [X_W-1:0] x_base;
    logic [X_W-1:0] x_end;
    logic [Y_W-1:0] y_end;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;

    // One extra bit keeps the far edge from wrapping before it is clipped
    always_comb begin
        x_sum   = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
        y_sum   = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);
        x_end_d = (x_sum > X_LAST) ? X_LAST[X_W-1:0] : x_sum[X_W-1:0];
        y_end_d = (y_sum > Y_LAST) ? Y_LAST[Y_W-1:0] : y_sum[Y_W-1:0];
        empty   = (w == '0) || (h == '0) || ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_base <= '0;
            x_end  <= '0;
            y_end  <= '0;
            cx     <= '0;
            cy     <= '0;
        end else if (start) begin
            x_base <= x0;
            x_end  <= x_end_d;
            y_end  <= y_end_d;
            cx     <= x0;
            cy     <= y0;
        end else if (step) begin
            if (cx == x_end) begin
                cx <= x_base;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    assign last = (cx == x_end) && (cy == y_end);
    assign addr = pack_addr(cy, cx);

endmodule

// File: rtl/fb_port_a_scheduler.sv
// rtl/fb_port_a_scheduler.sv - round-robin sharing of frame-buffer port A between CPU and fill engine
module fb_port_a_scheduler
    import fb_pkg::*;
#(
    parameter int HorRes  = 160,
    parameter int VertRes = 120
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic              CPU_WDATA,
    output logic              CPU_ACK,
    output logic              CPU_RVALID,
    output logic              CPU_RDATA,
    input  logic              FILL_START,
    input  logic [X_W-1:0]    FILL_X0,
    input  logic [Y_W-1:0]    FILL_Y0,
    input  logic [X_W-1:0]    FILL_W,
    input  logic [Y_W-1:0]    FILL_H,
    input  logic              FILL_COLOUR,
    output logic              FILL_BUSY,
    output logic              FILL_DONE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic              FB_WE,
    output logic              FB_WDATA,
    input  logic              FB_RDATA
);

    fb_state_t         state;
    logic              last_cpu;
    logic              colour;
    logic              rd_stage;
    logic              cpu_elig;
    logic              fill_elig;
    logic              grant_cpu;
    logic              grant_fill;
    logic              walk_start;
    logic              walk_empty;
    logic              walk_last;
    logic [ADDR_W-1:0] walk_addr;

    // A CPU that was just acknowledged sits out one cycle so a slow REQ drop cannot re-issue
    assign cpu_elig   = CPU_REQ && !CPU_ACK;
    assign fill_elig  = (state == ST_FILL);
    assign grant_cpu  = cpu_elig && (!fill_elig || !last_cpu);
    assign grant_fill = fill_elig && !grant_cpu;
    assign walk_start = (state == ST_IDLE) && FILL_START;

    fb_rect_walker #(
        .HOR_RES  (HorRes),
        .VERT_RES (VertRes)
    ) u_walker (
        .clk   (CLK),
        .rst_n (RESET_N),
        .start (walk_start),
        .step  (grant_fill),
        .x0    (FILL_X0),
        .y0    (FILL_Y0),
        .w     (FILL_W),
        .h     (FILL_H),
        .empty (walk_empty),
        .last  (walk_last),
        .addr  (walk_addr)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            colour <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (FILL_START) begin
                        colour <= FILL_COLOUR;
                        state  <= walk_empty ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (grant_fill && walk_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_cpu <= 1'b1;
        end else if (grant_cpu) begin
            last_cpu <= 1'b1;
        end else if (grant_fill) begin
            last_cpu <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            CPU_ACK   <= 1'b0;
            FILL_BUSY <= 1'b0;
            FILL_DONE <= 1'b0;
            FB_ADDR   <= '0;
            FB_WE     <= 1'b0;
            FB_WDATA  <= 1'b0;
        end else begin
            CPU_ACK   <= grant_cpu;
            FILL_BUSY <= (state == ST_FILL);
            FILL_DONE <= (state == ST_DONE);
            if (grant_cpu) begin
                FB_ADDR  <= CPU_ADDR;
                FB_WE    <= CPU_WE;
                FB_WDATA <= CPU_WDATA;
            end else if (grant_fill) begin
                FB_ADDR  <= walk_addr;
                FB_WE    <= 1'b1;
                FB_WDATA <= colour;
            end else begin
                FB_WE    <= 1'b0;
            end
        end
    end

    // Read data leaves the RAM one cycle after the ACK cycle and is registered the cycle after
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_stage   <= 1'b0;
            CPU_RVALID <= 1'b0;
            CPU_RDATA  <= 1'b0;
        end else begin
            rd_stage   <= CPU_ACK && !FB_WE;
            CPU_RVALID <= rd_stage;
            if (rd_stage) begin
                CPU_RDATA <= FB_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_a_scheduler.sv
// tb/tb_fb_port_a_scheduler.sv - self-checking bench for fb_port_a_scheduler
module tb_fb_port_a_scheduler;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CPU_REQ = 1'b0;
    logic        CPU_WE = 1'b0;
    logic [14:0] CPU_ADDR = '0;
    logic        CPU_WDATA = 1'b0;
    logic        CPU_ACK;
    logic        CPU_RVALID;
    logic        CPU_RDATA;
    logic        FILL_START = 1'b0;
    logic [7:0]  FILL_X0 = '0;
    logic [6:0]  FILL_Y0 = '0;
    logic [7:0]  FILL_W = '0;
    logic [6:0]  FILL_H = '0;
    logic        FILL_COLOUR = 1'b0;
    logic        FILL_BUSY;
    logic        FILL_DONE;
    logic [14:0] FB_ADDR;
    logic        FB_WE;
    logic        FB_WDATA;
    logic        FB_RDATA;

    fb_port_a_scheduler #(.HorRes(160), .VertRes(120)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .CPU_REQ     (CPU_REQ),
        .CPU_WE      (CPU_WE),
        .CPU_ADDR    (CPU_ADDR),
        .CPU_WDATA   (CPU_WDATA),
        .CPU_ACK     (CPU_ACK),
        .CPU_RVALID  (CPU_RVALID),
        .CPU_RDATA   (CPU_RDATA),
        .FILL_START  (FILL_START),
        .FILL_X0     (FILL_X0),
        .FILL_Y0     (FILL_Y0),
        .FILL_W      (FILL_W),
        .FILL_H      (FILL_H),
        .FILL_COLOUR (FILL_COLOUR),
        .FILL_BUSY   (FILL_BUSY),
        .FILL_DONE   (FILL_DONE),
        .FB_ADDR     (FB_ADDR),
        .FB_WE       (FB_WE),
        .FB_WDATA    (FB_WDATA),
        .FB_RDATA    (FB_RDATA)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Synchronous frame-buffer RAM: read data appears one cycle after the address
    bit   fb_mem [0:32767];
    logic fb_rd_q = 1'b0;
    assign FB_RDATA = fb_rd_q;
    always @(posedge CLK) begin
        if (FB_WE === 1'b1) fb_mem[FB_ADDR] <= FB_WDATA;
        fb_rd_q <= fb_mem[FB_ADDR];
    end

    // Reference model: fill = list of pixel addresses, arbitration = alternate when both want port
    bit          ref_mem [0:32767];
    logic        m_ack = 0, m_rv = 0, m_rd = 0, m_busy = 0, m_done = 0, m_we = 0, m_wd = 0;
    logic [14:0] m_addr = '0;
    int          m_phase = 0;
    int          m_old;
    logic        m_last_cpu = 1'b1;
    logic        m_colour = 1'b0;
    logic [14:0] m_pix [$];
    logic        rv_p0 = 0, rv_p1 = 0, rd_p0 = 0, rd_p1 = 0;
    logic        m_ce, m_fe, m_gc, m_gf;
    int          xe, ye;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_ack = 0; m_rv = 0; m_rd = 0; m_busy = 0; m_done = 0;
            m_we = 0; m_wd = 0; m_addr = '0; m_phase = 0; m_last_cpu = 1;
            m_colour = 0; m_pix.delete();
            rv_p0 = 0; rv_p1 = 0; rd_p0 = 0; rd_p1 = 0;
        end else begin
            m_ce = CPU_REQ && !m_ack;
            m_fe = (m_phase == 1);
            m_gc = m_ce && (!m_fe || !m_last_cpu);
            m_gf = m_fe && !m_gc;
            m_old = m_phase;
            m_rv = rv_p1;
            if (rv_p1) m_rd = rd_p1;
            rv_p1 = rv_p0;
            rd_p1 = rd_p0;
            rv_p0 = m_gc && !CPU_WE;
            m_busy = (m_old == 1);
            m_done = (m_old == 2);
            m_ack = m_gc;
            if (m_gc) begin
                m_addr = CPU_ADDR; m_we = CPU_WE; m_wd = CPU_WDATA; m_last_cpu = 1;
                if (CPU_WE) ref_mem[CPU_ADDR] = CPU_WDATA;
                else rd_p0 = ref_mem[CPU_ADDR];
            end else if (m_gf) begin
                m_addr = m_pix.pop_front(); m_we = 1; m_wd = m_colour; m_last_cpu = 0;
                ref_mem[m_addr] = m_colour;
                if (m_pix.size() == 0) m_phase = 2;
            end else begin
                m_we = 0;
            end
            if (m_old == 2) m_phase = 0;
            if (m_old == 0 && FILL_START) begin
                m_colour = FILL_COLOUR;
                if (FILL_W == 0 || FILL_H == 0 || FILL_X0 >= 160 || FILL_Y0 >= 120) begin
                    m_phase = 2;
                end else begin
                    xe = int'(FILL_X0) + int'(FILL_W) - 1;
                    ye = int'(FILL_Y0) + int'(FILL_H) - 1;
                    if (xe > 159) xe = 159;
                    if (ye > 119) ye = 119;
                    for (int y = int'(FILL_Y0); y <= ye; y++)
                        for (int x = int'(FILL_X0); x <= xe; x++)
                            m_pix.push_back({7'(y), 8'(x)});
                    m_phase = 1;
                end
            end
        end
    end

    // Per-cycle compare plus a log of observed traffic for the literal checks
    logic [14:0] fill_log [$];
    int          fill_cyc [$];
    int          done_cyc = -1;
    int          done_n = 0;
    int          busy_n = 0;
    int          ack_n = 0;

    always @(negedge CLK) begin
        check("cpu_ack", CPU_ACK, m_ack);
        check("cpu_rvalid", CPU_RVALID, m_rv);
        if (m_rv) check("cpu_rdata", CPU_RDATA, m_rd);
        check("fill_busy", FILL_BUSY, m_busy);
        check("fill_done", FILL_DONE, m_done);
        check("fb_we", FB_WE, m_we);
        check("fb_addr", FB_ADDR, m_addr);
        check("fb_wdata", FB_WDATA, m_wd);
        if (FB_WE && !CPU_ACK) begin
            fill_log.push_back(FB_ADDR);
            fill_cyc.push_back(cyc);
        end
        if (FILL_DONE) begin
            done_cyc = cyc;
            done_n++;
        end
        if (FILL_BUSY) busy_n++;
        if (CPU_ACK) ack_n++;
    end

    task automatic clear_logs();
        fill_log.delete();
        fill_cyc.delete();
        done_cyc = -1;
        done_n = 0;
        busy_n = 0;
        ack_n = 0;
    endtask

    task automatic start_fill(input int x0, input int y0, input int w, input int h, input logic col, output int s);
        FILL_X0 = 8'(x0); FILL_Y0 = 7'(y0); FILL_W = 8'(w); FILL_H = 7'(h);
        FILL_COLOUR = col; FILL_START = 1'b1;
        s = cyc + 1;
        @(negedge CLK);
        FILL_START = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!FILL_DONE && k < limit) begin
            @(negedge CLK);
            k++;
        end
        if (!FILL_DONE) check("done_timeout", FILL_DONE, 1);
    endtask

    logic [14:0] exp_rect [6];
    int s;

    initial begin
        exp_rect = '{15'h140A, 15'h140B, 15'h140C, 15'h150A, 15'h150B, 15'h150C};
        repeat (3) @(negedge CLK);
        check("rst_fb_addr", FB_ADDR, 15'h0000);
        check("rst_fb_we", FB_WE, 0);
        check("rst_busy", FILL_BUSY, 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // CPU write then read-back of {Y=5, X=7}
        CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 15'h0507; CPU_WDATA = 1;
        @(negedge CLK);
        check("wr_ack", CPU_ACK, 1);
        check("wr_addr", FB_ADDR, 15'h0507);
        check("wr_we", FB_WE, 1);
        check("wr_data", FB_WDATA, 1);
        CPU_REQ = 0;
        @(negedge CLK);
        CPU_REQ = 1; CPU_WE = 0;
        @(negedge CLK);
        check("rd_ack", CPU_ACK, 1);
        CPU_REQ = 0;
        @(negedge CLK);
        check("rd_rvalid_c1", CPU_RVALID, 0);
        @(negedge CLK);
        check("rd_rvalid_c2", CPU_RVALID, 1);
        check("rd_rdata", CPU_RDATA, 1);
        repeat (3) @(negedge CLK);

        // 3x2 fill, uncontended
        clear_logs();
        start_fill(10, 20, 3, 2, 1'b1, s);
        wait_done(50);
        repeat (3) @(negedge CLK);
        check("rect_count", fill_log.size(), 6);
        for (int i = 0; i < 6 && i < fill_log.size(); i++) check("rect_addr", fill_log[i], exp_rect[i]);
        if (fill_cyc.size() == 6) begin
            check("rect_first_cyc", fill_cyc[0], s + 1);
            check("rect_last_cyc", fill_cyc[5], s + 6);
        end
        check("rect_done_cyc", done_cyc, s + 7);
        check("rect_busy_n", busy_n, 6);

        // Clipped at bottom-right corner
        clear_logs();
        start_fill(158, 119, 5, 4, 1'b1, s);
        wait_done(50);
        repeat (3) @(negedge CLK);
        check("clip_count", fill_log.size(), 2);
        if (fill_log.size() == 2) begin
            check("clip_addr0", fill_log[0], 15'h779E);
            check("clip_addr1", fill_log[1], 15'h779F);
        end
        check("clip_done_cyc", done_cyc, s + 3);

        // Zero width
        clear_logs();
        start_fill(5, 5, 0, 3, 1'b1, s);
        wait_done(20);
        repeat (3) @(negedge CLK);
        check("empty_count", fill_log.size(), 0);
        check("empty_done_cyc", done_cyc, s + 1);

        // CPU held requesting throughout a 10-pixel fill
        clear_logs();
        CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 15'h7F00; CPU_WDATA = 0;
        start_fill(0, 2, 10, 1, 1'b1, s);
        wait_done(100);
        CPU_REQ = 0;
        repeat (3) @(negedge CLK);
        check("rr_fill_count", fill_log.size(), 10);
        if (fill_cyc.size() == 10) begin
            check("rr_first_cyc", fill_cyc[0], s + 1);
            check("rr_last_cyc", fill_cyc[9], s + 19);
        end
        check("rr_done_cyc", done_cyc, s + 20);
        check("rr_ack_n", ack_n, 11);

        // Asynchronous reset in the middle of a fill
        clear_logs();
        start_fill(0, 10, 20, 1, 1'b1, s);
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_we", FB_WE, 0);
        check("arst_addr", FB_ADDR, 0);
        check("arst_busy", FILL_BUSY, 0);
        check("arst_wdata", FB_WDATA, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        check("arst_no_done", done_n, 0);
        clear_logs();
        start_fill(30, 40, 2, 1, 1'b0, s);
        wait_done(20);
        repeat (3) @(negedge CLK);
        check("post_rst_count", fill_log.size(), 2);
        check("post_rst_done_cyc", done_cyc, s + 3);

        // START while busy, and START in the DONE cycle, are both ignored
        clear_logs();
        start_fill(50, 60, 4, 2, 1'b1, s);
        for (int k = 0; k < 40 && !FILL_DONE; k++) begin
            if (cyc == s + 3) begin
                FILL_X0 = 0; FILL_Y0 = 0; FILL_W = 100; FILL_H = 100; FILL_START = 1;
            end else if (cyc == s + 8) begin
                FILL_X0 = 5; FILL_Y0 = 5; FILL_W = 1; FILL_H = 1; FILL_START = 1;
            end else begin
                FILL_START = 0;
            end
            @(negedge CLK);
        end
        FILL_START = 0;
        repeat (6) @(negedge CLK);
        check("busy_start_count", fill_log.size(), 8);
        if (fill_log.size() == 8) begin
            check("busy_start_first", fill_log[0], 15'h3C32);
            check("busy_start_last", fill_log[7], 15'h3D35);
        end
        check("busy_start_done_n", done_n, 1);
        check("busy_start_done_cyc", done_cyc, s + 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
